cmdack_arb: RTL and testbench

Multi-channel successor to the single-channel command/acknowledge latch. Each of NCH requesters raises a level command. The block latches it, arbitrates round-robin, and presents one command at a time to a shared downstream executor as cmd_valid/cmd_id, held until cmd_ack. Each channel re-arms only after its command level returns low. Sits between per-source command decoders and the single DTC command executor.

---
 rtl/cmdack_arb_if.sv | 24 ++
 rtl/cmdack_arb.sv | 133 +++++++++++++
 tb/tb_cmdack_arb.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/cmdack_arb_if.sv
// Command/acknowledge bundle between the per-source requesters, the arbiter and the executor.
// The slave modport is the arbiter's view; master is the driving side.
interface cmdack_arb_if #(
  parameter int NCH = 4,
  parameter int IDW = 2
);
  logic [NCH-1:0] cmd;
  logic           cmd_ack;
  logic           cmd_valid;
  logic [IDW-1:0] cmd_id;
  logic [NCH-1:0] busy;
  logic [NCH-1:0] done;
  logic [NCH-1:0] timeout;

  modport master (
    output cmd, cmd_ack,
    input  cmd_valid, cmd_id, busy, done, timeout
  );

  modport slave (
    input  cmd, cmd_ack,
    output cmd_valid, cmd_id, busy, done, timeout
  );
endinterface

// File: rtl/cmdack_arb.sv
// Round-robin arbiter that latches NCH level commands and issues them one at a time to a shared executor.
// Optional ack timeout is enabled by defining CMDACK_ARB_TIMEOUT_EN.
module cmdack_arb #(
  parameter int NCH       = 4,
  parameter int IDW       = 2,
  parameter int TO_W      = 16,
  parameter int TO_CYCLES = 1000
) (
  input logic          clk,
  input logic          reset,
  cmdack_arb_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, PEND, ACTIVE, WAIT} state_e;

  if ((NCH < 2) || (NCH > 16) || ((2 ** IDW) < NCH) ||
      (TO_CYCLES < 1) || (TO_CYCLES > (2 ** TO_W) - 1)) begin : g_param_err
    $error("cmdack_arb: illegal parameter combination");
  end

  state_e         st_q [NCH];
  state_e         st_d [NCH];
  logic [IDW-1:0] rr_q, rr_d;
  logic           cmd_valid_q, cmd_valid_d;
  logic [IDW-1:0] cmd_id_q, cmd_id_d;
  logic [NCH-1:0] busy_q, busy_d;
  logic [NCH-1:0] done_q, done_d;
  logic [NCH-1:0] timeout_q, timeout_d;
  logic           free;
  logic           gnt_vld;
  logic [IDW-1:0] gnt_idx;
  logic           expire;

  function automatic int wrapIdx(input int base, input int k);
    int s;
    s = base + k;
    return (s >= NCH) ? s - NCH : s;
  endfunction

`ifdef CMDACK_ARB_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt_q;
  assign expire = (to_cnt_q == TO_W'(TO_CYCLES - 1));
`else
  assign expire = 1'b0;
`endif

  // A PEND channel whose command has just dropped is skipped so a cancel never gets issued.
  always_comb begin
    free    = 1'b1;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < NCH; i++) begin
      if (st_q[i] == ACTIVE) free = 1'b0;
    end
    for (int k = 1; k <= NCH; k++) begin
      if (free && !gnt_vld && (st_q[wrapIdx(int'(rr_q), k)] == PEND) &&
          bus.cmd[wrapIdx(int'(rr_q), k)]) begin
        gnt_vld = 1'b1;
        gnt_idx = IDW'(wrapIdx(int'(rr_q), k));
      end
    end
  end

  always_comb begin
    rr_d        = gnt_vld ? gnt_idx : rr_q;
    cmd_valid_d = 1'b0;
    cmd_id_d    = '0;
    busy_d      = '0;
    done_d      = '0;
    timeout_d   = '0;
    for (int i = 0; i < NCH; i++) begin
      st_d[i] = st_q[i];
      case (st_q[i])
        IDLE:    if (bus.cmd[i]) st_d[i] = PEND;
        PEND: begin
          if (!bus.cmd[i])                           st_d[i] = IDLE;
          else if (gnt_vld && (gnt_idx == IDW'(i)))  st_d[i] = ACTIVE;
        end
        ACTIVE: begin
          if (bus.cmd_ack) begin
            st_d[i]   = WAIT;
            done_d[i] = 1'b1;
          end else if (expire) begin
            st_d[i]      = WAIT;
            timeout_d[i] = 1'b1;
          end
        end
        WAIT:    if (!bus.cmd[i]) st_d[i] = IDLE;
        default: st_d[i] = IDLE;
      endcase
      if (st_d[i] == ACTIVE) begin
        cmd_valid_d = 1'b1;
        cmd_id_d    = IDW'(i);
      end
      busy_d[i] = (st_d[i] == PEND) || (st_d[i] == ACTIVE);
    end
  end

  // Outputs are registered from next state so they line up with the channel states.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) st_q[i] <= IDLE;
      rr_q        <= IDW'(NCH - 1);
      cmd_valid_q <= 1'b0;
      cmd_id_q    <= '0;
      busy_q      <= '0;
      done_q      <= '0;
      timeout_q   <= '0;
`ifdef CMDACK_ARB_TIMEOUT_EN
      to_cnt_q    <= '0;
`endif
    end else begin
      for (int i = 0; i < NCH; i++) st_q[i] <= st_d[i];
      rr_q        <= rr_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_id_q    <= cmd_id_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
`ifdef CMDACK_ARB_TIMEOUT_EN
      if (gnt_vld)                    to_cnt_q <= '0;
      else if (!free && !bus.cmd_ack) to_cnt_q <= to_cnt_q + 1'b1;
`endif
    end
  end

  assign bus.cmd_valid = cmd_valid_q;
  assign bus.cmd_id    = cmd_id_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_cmdack_arb.sv
// Self-checking bench for cmdack_arb: directed scenarios plus random traffic against a queue/flag level model.
// Timeout scenario runs only when CMDACK_ARB_TIMEOUT_EN is defined.
module tb_cmdack_arb;
  localparam int NCH       = 4;
  localparam int IDW       = 2;
  localparam int TO_W      = 16;
  localparam int TO_CYCLES = 8;
`ifdef CMDACK_ARB_TIMEOUT_EN
  localparam bit ToEn = 1'b1;
`else
  localparam bit ToEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cmdack_arb_if #(.NCH(NCH), .IDW(IDW)) bus ();

  cmdack_arb #(.NCH(NCH), .IDW(IDW), .TO_W(TO_W), .TO_CYCLES(TO_CYCLES)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  bit             mPend  [NCH];
  bit             mSpent [NCH];
  int             mAct;
  int             mRr;
  int             mTcnt;
  logic [NCH-1:0] mDone;
  logic [NCH-1:0] mTo;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model: pending flags, "already served" flags, one active index, a round-robin pointer.
  task automatic modelStep();
    bit oPend [NCH];
    bit oSpent[NCH];
    int oAct;
    int base;
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin mPend[i] = 0; mSpent[i] = 0; end
      mAct = -1; mRr = NCH - 1; mTcnt = 0; mDone = '0; mTo = '0;
    end else begin
      oPend = mPend; oSpent = mSpent; oAct = mAct; base = mRr;
      mDone = '0; mTo = '0;
      if (oAct >= 0) begin
        if (bus.cmd_ack) begin
          mDone[oAct] = 1'b1; mSpent[oAct] = 1; mAct = -1;
        end else if (ToEn && mTcnt == TO_CYCLES - 1) begin
          mTo[oAct] = 1'b1; mSpent[oAct] = 1; mAct = -1;
        end else begin
          mTcnt++;
        end
      end else begin
        for (int k = 1; k <= NCH; k++) begin
          int c;
          c = (base + k) % NCH;
          if (mAct < 0 && oPend[c] && bus.cmd[c]) begin
            mAct = c; mRr = c; mTcnt = 0;
          end
        end
      end
      for (int i = 0; i < NCH; i++) begin
        if (oAct < 0 && mAct == i)                                mPend[i] = 0;
        else if (oPend[i] && !bus.cmd[i])                         mPend[i] = 0;
        else if (!oPend[i] && !oSpent[i] && oAct != i && bus.cmd[i]) mPend[i] = 1;
        if (oSpent[i] && !bus.cmd[i]) mSpent[i] = 0;
      end
    end
  endtask

  task automatic checkOutput();
    logic [NCH-1:0] expBusy;
    for (int i = 0; i < NCH; i++) expBusy[i] = mPend[i] || (mAct == i);
    checkVal("cmd_valid", 32'(bus.cmd_valid), 32'(mAct >= 0));
    checkVal("cmd_id",    32'(bus.cmd_id),    (mAct >= 0) ? 32'(mAct) : 32'd0);
    checkVal("busy",      32'(bus.busy),      32'(expBusy));
    checkVal("done",      32'(bus.done),      32'(mDone));
    checkVal("timeout",   32'(bus.timeout),   32'(mTo));
  endtask

  task automatic applyStimulus(input logic [NCH-1:0] c, input logic a, input logic r);
    bus.cmd = c; bus.cmd_ack = a; reset = r;
    modelStep();
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    int ids[$];
    bit prevV;
    bit sawId1;
    bit sawDone1;
    int vc;
    bit sawTo;
    bit sawDone;
    logic [NCH-1:0] rc;

    bus.cmd = '0; bus.cmd_ack = 1'b0; reset = 1'b1;
    mAct = -1; mRr = NCH - 1; mTcnt = 0; mDone = '0; mTo = '0;
    for (int i = 0; i < NCH; i++) begin mPend[i] = 0; mSpent[i] = 0; end

    applyStimulus(4'b0000, 1'b0, 1'b1);
    applyStimulus(4'b0000, 1'b0, 1'b1);
    checkVal("rst_outs", {bus.cmd_valid, bus.cmd_id, bus.busy, bus.done, bus.timeout}, 32'd0);

    $display("[TB] single request");
    applyStimulus(4'b0001, 1'b0, 1'b0);
    checkVal("t1_pend_busy", 32'(bus.busy), 32'h1);
    applyStimulus(4'b0001, 1'b0, 1'b0);
    checkVal("t1_valid", 32'(bus.cmd_valid), 32'd1);
    checkVal("t1_id", 32'(bus.cmd_id), 32'd0);
    applyStimulus(4'b0001, 1'b1, 1'b0);
    checkVal("t1_done", 32'(bus.done), 32'h1);
    checkVal("t1_drop", {bus.cmd_valid, bus.busy}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b0001, 1'b0, 1'b0);
      checkVal("t1_noreissue", 32'(bus.cmd_valid), 32'd0);
    end
    applyStimulus(4'b0000, 1'b0, 1'b0);
    applyStimulus(4'b0001, 1'b0, 1'b0);
    applyStimulus(4'b0001, 1'b0, 1'b0);
    checkVal("t1_second", 32'(bus.cmd_valid), 32'd1);
    applyStimulus(4'b0001, 1'b1, 1'b0);

    $display("[TB] round robin");
    applyStimulus(4'b0000, 1'b0, 1'b1);
    prevV = 1'b0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus((i == 3) ? 4'b1110 : 4'b1111, 1'(mAct >= 0), 1'b0);
      if (bus.cmd_valid && !prevV) ids.push_back(int'(bus.cmd_id));
      prevV = bus.cmd_valid;
    end
    checkVal("rr_count", 32'(ids.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      checkVal("rr_order", (i < ids.size()) ? 32'(ids[i]) : 32'hFF, (i == 4) ? 32'd0 : 32'(i));

    $display("[TB] cancel");
    applyStimulus(4'b0000, 1'b0, 1'b1);
    applyStimulus(4'b1000, 1'b0, 1'b0);
    applyStimulus(4'b1000, 1'b0, 1'b0);
    applyStimulus(4'b1010, 1'b0, 1'b0);
    checkVal("t3_busy1", 32'(bus.busy), 32'b1010);
    sawId1 = 0; sawDone1 = 0;
    applyStimulus(4'b1000, 1'b0, 1'b0);
    checkVal("t3_busy_fall", 32'(bus.busy), 32'b1000);
    applyStimulus(4'b1000, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'b0000, 1'b0, 1'b0);
      if (bus.cmd_valid && bus.cmd_id == 2'd1) sawId1 = 1;
      if (bus.done[1]) sawDone1 = 1;
    end
    checkVal("t3_no_id1", 32'(sawId1), 32'd0);
    checkVal("t3_no_done1", 32'(sawDone1), 32'd0);

    $display("[TB] spurious ack");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b0000, 1'b1, 1'b0);
      checkVal("t4_quiet", {bus.cmd_valid, bus.cmd_id, bus.busy, bus.done, bus.timeout}, 32'd0);
    end

`ifdef CMDACK_ARB_TIMEOUT_EN
    $display("[TB] timeout");
    applyStimulus(4'b0000, 1'b0, 1'b1);
    vc = 0; sawTo = 0; sawDone = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(4'b0100, 1'b0, 1'b0);
      if (bus.cmd_valid) vc++;
      if (bus.timeout[2]) sawTo = 1;
      if (bus.done != '0) sawDone = 1;
    end
    checkVal("t5_valid_cycles", 32'(vc), 32'd8);
    checkVal("t5_timeout", 32'(sawTo), 32'd1);
    checkVal("t5_no_done", 32'(sawDone), 32'd0);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    vc = 0; sawTo = 0; sawDone = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.cmd_valid) vc++;
      applyStimulus(4'b0100, 1'(bus.cmd_valid && vc == 8), 1'b0);
      if (bus.timeout != '0) sawTo = 1;
      if (bus.done[2]) sawDone = 1;
    end
    checkVal("t5b_done", 32'(sawDone), 32'd1);
    checkVal("t5b_no_timeout", 32'(sawTo), 32'd0);
`endif

    $display("[TB] reset mid-active");
    applyStimulus(4'b0000, 1'b0, 1'b1);
    applyStimulus(4'b0010, 1'b0, 1'b0);
    applyStimulus(4'b0010, 1'b0, 1'b0);
    checkVal("t6_active", 32'(bus.cmd_id), 32'd1);
    applyStimulus(4'b0010, 1'b0, 1'b1);
    checkVal("t6_rst_outs", {bus.cmd_valid, bus.cmd_id, bus.busy, bus.done, bus.timeout}, 32'd0);
    applyStimulus(4'b0010, 1'b0, 1'b0);
    applyStimulus(4'b0010, 1'b0, 1'b0);
    checkVal("t6_reissue_valid", 32'(bus.cmd_valid), 32'd1);
    checkVal("t6_reissue_id", 32'(bus.cmd_id), 32'd1);

    $display("[TB] random traffic");
    rc = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) rc[$urandom_range(NCH - 1)] ^= 1'b1;
      applyStimulus(rc, 1'($urandom_range(2) == 0), 1'($urandom_range(299) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
